hog_norm_frame_sequencer: RTL and testbench
===========================================

Name: hog_norm_frame_sequencer

Overview:
- Frame-level controller for the HOG histogram → normalization/PCA/hamming datapath.
- Issues the histogram start pulse and hands histogram BRAM port ownership from the histogram engine to the normalization engine.
- Generates the `histogram_done` pulse and counts the 31 feature outputs per cell until the configured cell count completes.
- Reports busy, frame completion and sticky error status to the AXI-lite register block.

Parameters:
- CELL_W, 16, width of cell count config and counter.
- SETTLE_CYC, 2, cycles between `hist_finish` and `histogram_done`, for final BRAM writes to land; legal range 1..15.
- WDOG_CYC, 65535, idle-cycle limit for the optional watchdog.

Ports:
- aclk  in  1  clock
- arest  in  1  synchronous active-high reset
- start  in  1  one-cycle frame start request from register block
- abort  in  1  one-cycle abort request
- cfg_cells  in  CELL_W  number of normalized cells expected this frame
- hist_start  out  1  one-cycle start pulse to histogram engine
- hist_finish  in  1  one-cycle pulse: histogram engine finished writing
- bram_sel  out  1  histogram BRAM owner: 0 = histogram engine, 1 = normalization engine
- histogram_done  out  1  one-cycle pulse to normalization pipeline
- bin0_17_feature_valid  in  1  feature stream strobe
- bin18_26_feature_valid  in  1  feature stream strobe
- bin27_30_feature_valid  in  1  feature stream strobe
- busy  out  1  high from start acceptance until frame end
- frame_done  out  1  one-cycle pulse at frame end (normal, error or timeout)
- cell_count  out  CELL_W  cells completed this frame
- status  out  3  sticky {timeout, seq_err, cfg_err}

Behaviour:
- Reset (synchronous, active-high):
  - state IDLE.
  - All outputs 0, including bram_sel, cell_count and status.
  - Reset mid-frame abandons the frame; no frame_done is generated.
- FSM states: IDLE, HIST, SETTLE, NORM, DONE.
- IDLE:
  - start=1: latch cfg_cells, clear status and cell_count, set busy next cycle.
  - If cfg_cells≠0: go to HIST; hist_start pulses exactly one cycle on the HIST entry cycle.
  - If cfg_cells=0: set cfg_err, go to DONE.
- start while busy: ignored, no side effect.
- HIST: bram_sel=0; wait for hist_finish; hist_finish → SETTLE.
- SETTLE:
  - bram_sel=1 from the first SETTLE cycle.
  - Wait SETTLE_CYC cycles, then enter NORM.
  - histogram_done pulses exactly one cycle, on the NORM entry cycle.
- NORM, per-stream counters:
  - c18 counts bin0_17 mod 18; c9 counts bin18_26 mod 9; c4 counts bin27_30 mod 4.
  - bin27_30_feature_valid with c4=3 completes a cell: cell_count+1.
  - At that event, if c18≠0 or c9≠0 (counting any same-cycle strobe), set seq_err.
  - The datapath emits a cell's bin27_30 after that cell's other bins.
  - cell_count reaching the latched cfg_cells → DONE the next cycle.
- DONE: frame_done pulse one cycle, busy=0, bram_sel=0, return to IDLE. cell_count and status hold until the next accepted start.
- Feature strobes outside NORM: ignored for counting, set seq_err.
- Strobes in the same cycle as the final cell completion: counted normally.
- abort (any non-IDLE state):
  - Next cycle → IDLE, busy=0, bram_sel=0.
  - No frame_done; status and cell_count hold.
- abort and start in the same cycle in IDLE: start wins.
- Latency figures:
  - start → hist_start: 1 cycle.
  - hist_finish → histogram_done: SETTLE_CYC+1 cycles.
  - Last bin27_30 → frame_done: 2 cycles.

Optional Feature:
- Macro HOG_SEQ_WATCHDOG_EN.
- When defined:
  - A 16-bit idle counter runs in HIST, SETTLE and NORM.
  - The counter clears on state entry, hist_finish, or any feature strobe.
  - Reaching WDOG_CYC sets status[2] (timeout) and goes to DONE, so frame_done pulses.
- When undefined: no counter, status[2] tied 0, the FSM can wait indefinitely.

Test Plan:
- Normal frame:
  - Stimulus: cfg_cells=3, start, hist_finish 10 cycles later, then 3×(18,9,4) strobes.
  - Response: hist_start 1 cycle after start; histogram_done 3 cycles after hist_finish; frame_done 2 cycles after the 12th bin27_30; cell_count=3; status=000.
- cfg_cells=0 with start → frame_done within 2 cycles, status=001, hist_start never asserted.
- Sequence error: cfg_cells=1, only 17 bin0_17 strobes before the 4th bin27_30 → status=010, frame_done still pulses, cell_count=1.
- abort in NORM after 1 of 2 cells → busy and bram_sel drop next cycle, no frame_done, cell_count=1; a following start restarts cleanly with status=000.
- start pulses during HIST → ignored, exactly one hist_start; arest asserted in SETTLE → all outputs 0 next cycle.
- Watchdog (HOG_SEQ_WATCHDOG_EN, WDOG_CYC=100): hist_finish withheld → frame_done at 100 idle cycles, status=100.

Source files
------------

// File: rtl/hog_norm_frame_sequencer_if.sv
// Datapath-side handshake bundle of the HOG frame sequencer.
//   hist_start      sequencer -> histogram engine, one-cycle start pulse
//   hist_finish     histogram engine -> sequencer, one-cycle finish pulse
//   bram_sel        histogram BRAM owner: 0 = histogram engine, 1 = normalization
//   histogram_done  sequencer -> normalization pipeline, one-cycle pulse
//   bin*_feature_valid  normalization feature stream strobes
// master = sequencer side, slave = datapath side.
interface hog_norm_frame_sequencer_if;
  logic hist_start;
  logic hist_finish;
  logic bram_sel;
  logic histogram_done;
  logic bin0_17_feature_valid;
  logic bin18_26_feature_valid;
  logic bin27_30_feature_valid;

  modport master (
    output hist_start, bram_sel, histogram_done,
    input  hist_finish, bin0_17_feature_valid, bin18_26_feature_valid,
           bin27_30_feature_valid
  );

  modport slave (
    input  hist_start, bram_sel, histogram_done,
    output hist_finish, bin0_17_feature_valid, bin18_26_feature_valid,
           bin27_30_feature_valid
  );
endinterface

// File: rtl/hog_norm_frame_sequencer.sv
// Frame-level controller for the HOG histogram -> normalization datapath.
// Starts the histogram engine, hands the histogram BRAM to the normalization
// engine after a settle delay, counts 31-feature cells until cfg_cells are done
// and reports busy / frame_done / sticky status {timeout, seq_err, cfg_err}.
// Ports:
//   aclk, arest   clock, synchronous active-high reset
//   start, abort  one-cycle requests from the register block
//   cfg_cells     cells expected this frame (latched at start)
//   dp            datapath handshake (master modport)
//   busy, frame_done, cell_count, status  register-block status
// Optional feature: define HOG_SEQ_WATCHDOG_EN to enable the idle watchdog
// (WDOG_CYC idle cycles in HIST/SETTLE/NORM -> timeout, frame ends).
module hog_norm_frame_sequencer #(
  parameter int CELL_W     = 16,
  parameter int SETTLE_CYC = 2,
  parameter int WDOG_CYC   = 65535
) (
  input  logic                       aclk,
  input  logic                       arest,
  input  logic                       start,
  input  logic                       abort,
  input  logic [CELL_W-1:0]          cfg_cells,
  hog_norm_frame_sequencer_if.master dp,
  output logic                       busy,
  output logic                       frame_done,
  output logic [CELL_W-1:0]          cell_count,
  output logic [2:0]                 status
);

  typedef enum logic [2:0] {IDLE, HIST, SETTLE, NORM, DONE} state_t;

  state_t              state;
  logic [CELL_W-1:0]   cfg_lat;
  logic [3:0]          settle_cnt;
  logic [4:0]          c18;
  logic [3:0]          c9;
  logic [1:0]          c4;

  logic [4:0]          c18_nx;
  logic [3:0]          c9_nx;
  logic [1:0]          c4_nx;
  logic                any_strobe;
  logic                cell_evt;
  logic [CELL_W-1:0]   cell_next;

`ifdef HOG_SEQ_WATCHDOG_EN
  localparam logic [15:0] WD_LAST = 16'(WDOG_CYC - 1);
  logic [15:0] wd_cnt;
`endif

  // Per-stream counters including any strobe arriving this cycle, so the
  // sequence check at cell completion sees the same-cycle bins.
  always_comb begin
    any_strobe = dp.bin0_17_feature_valid | dp.bin18_26_feature_valid |
                 dp.bin27_30_feature_valid;
    c18_nx = c18;
    c9_nx  = c9;
    c4_nx  = c4;
    if (dp.bin0_17_feature_valid)  c18_nx = (c18 == 5'd17) ? 5'd0 : c18 + 5'd1;
    if (dp.bin18_26_feature_valid) c9_nx  = (c9 == 4'd8)   ? 4'd0 : c9 + 4'd1;
    if (dp.bin27_30_feature_valid) c4_nx  = c4 + 2'd1;
    cell_evt  = (state == NORM) && dp.bin27_30_feature_valid && (c4 == 2'd3);
    cell_next = cell_count + CELL_W'(1);
  end

  always_ff @(posedge aclk) begin
    if (arest) begin
      state             <= IDLE;
      cfg_lat           <= '0;
      settle_cnt        <= '0;
      c18               <= '0;
      c9                <= '0;
      c4                <= '0;
      busy              <= 1'b0;
      frame_done        <= 1'b0;
      cell_count        <= '0;
      status            <= '0;
      dp.hist_start     <= 1'b0;
      dp.bram_sel       <= 1'b0;
      dp.histogram_done <= 1'b0;
`ifdef HOG_SEQ_WATCHDOG_EN
      wd_cnt            <= '0;
`endif
    end else begin
      dp.hist_start     <= 1'b0;
      dp.histogram_done <= 1'b0;
      frame_done        <= 1'b0;
      if (state != IDLE && abort) begin
        state       <= IDLE;
        busy        <= 1'b0;
        dp.bram_sel <= 1'b0;
      end else begin
        // Strobes outside NORM are protocol errors only while a frame is
        // active; in IDLE they would corrupt the status held from last frame.
        if (state inside {HIST, SETTLE, DONE} && any_strobe) status[1] <= 1'b1;
        case (state)
          IDLE: begin
            if (start) begin
              cfg_lat    <= cfg_cells;
              cell_count <= '0;
              c18        <= '0;
              c9         <= '0;
              c4         <= '0;
              busy       <= 1'b1;
              if (cfg_cells == '0) begin
                status <= 3'b001;
                state  <= DONE;
              end else begin
                status        <= '0;
                dp.hist_start <= 1'b1;
                state         <= HIST;
              end
            end
          end
          HIST: begin
            if (dp.hist_finish) begin
              state       <= SETTLE;
              dp.bram_sel <= 1'b1;
              settle_cnt  <= '0;
            end
          end
          SETTLE: begin
            if (settle_cnt == 4'(SETTLE_CYC - 1)) begin
              state             <= NORM;
              dp.histogram_done <= 1'b1;
            end else begin
              settle_cnt <= settle_cnt + 4'd1;
            end
          end
          NORM: begin
            c18 <= c18_nx;
            c9  <= c9_nx;
            c4  <= c4_nx;
            if (cell_evt) begin
              cell_count <= cell_next;
              if (c18_nx != '0 || c9_nx != '0) status[1] <= 1'b1;
              if (cell_next == cfg_lat) begin
                state       <= DONE;
                dp.bram_sel <= 1'b0;
              end
            end
          end
          DONE: begin
            frame_done  <= 1'b1;
            busy        <= 1'b0;
            dp.bram_sel <= 1'b0;
            state       <= IDLE;
          end
          default: state <= IDLE;
        endcase
`ifdef HOG_SEQ_WATCHDOG_EN
        // Idle counter restarts on every state change and on any datapath
        // activity; timeout overrides whatever transition the case chose.
        if (!(state inside {HIST, SETTLE, NORM}) || dp.hist_finish || any_strobe ||
            (state == SETTLE && settle_cnt == 4'(SETTLE_CYC - 1))) begin
          wd_cnt <= '0;
        end else if (wd_cnt == WD_LAST) begin
          wd_cnt            <= '0;
          status[2]         <= 1'b1;
          state             <= DONE;
          dp.bram_sel       <= 1'b0;
          dp.histogram_done <= 1'b0;
        end else begin
          wd_cnt <= wd_cnt + 16'd1;
        end
`endif
      end
    end
  end

endmodule

// File: tb/tb_hog_norm_frame_sequencer.sv
module tb_hog_norm_frame_sequencer;
  localparam int CELL_W = 16;
`ifdef HOG_SEQ_WATCHDOG_EN
  localparam int TB_WDOG = 100;
`else
  localparam int TB_WDOG = 65535;
`endif

  logic              aclk = 1'b0;
  logic              arest, start, abort;
  logic [CELL_W-1:0] cfg_cells;
  logic              busy, frame_done;
  logic [CELL_W-1:0] cell_count;
  logic [2:0]        status;

  hog_norm_frame_sequencer_if dp();

  hog_norm_frame_sequencer #(
    .CELL_W(CELL_W),
    .SETTLE_CYC(2),
    .WDOG_CYC(TB_WDOG)
  ) dut (
    .aclk(aclk),
    .arest(arest),
    .start(start),
    .abort(abort),
    .cfg_cells(cfg_cells),
    .dp(dp),
    .busy(busy),
    .frame_done(frame_done),
    .cell_count(cell_count),
    .status(status)
  );

  always #5 aclk = ~aclk;

  int checks = 0;
  int failures = 0;
  int fd_seen = 0;
  int hs_seen = 0;
  int fd0, hs0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One clock: inputs set before the call are sampled at this edge, outputs
  // are read 1 time unit after it.
  task automatic tick();
    @(posedge aclk);
    #1;
    if (frame_done === 1'b1) fd_seen++;
    if (dp.hist_start === 1'b1) hs_seen++;
  endtask

  task automatic start_frame(input logic [CELL_W-1:0] cfg);
    cfg_cells = cfg;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // hist_finish -> SETTLE (2 cycles) -> NORM with histogram_done.
  task automatic to_norm(input string tag);
    dp.hist_finish = 1'b1;
    tick();
    dp.hist_finish = 1'b0;
    check({tag, "_settle_bram_sel"}, 32'(dp.bram_sel), 32'd1);
    tick();
    check({tag, "_hd_early"}, 32'(dp.histogram_done), 32'd0);
    tick();
    check({tag, "_hd_pulse"}, 32'(dp.histogram_done), 32'd1);
  endtask

  task automatic strobes(input int n0, input int n1, input int n2);
    dp.bin0_17_feature_valid = 1'b1;
    repeat (n0) tick();
    dp.bin0_17_feature_valid = 1'b0;
    dp.bin18_26_feature_valid = 1'b1;
    repeat (n1) tick();
    dp.bin18_26_feature_valid = 1'b0;
    dp.bin27_30_feature_valid = 1'b1;
    repeat (n2) tick();
    dp.bin27_30_feature_valid = 1'b0;
  endtask

  initial begin
    arest = 1'b1;
    start = 1'b0;
    abort = 1'b0;
    cfg_cells = '0;
    dp.hist_finish = 1'b0;
    dp.bin0_17_feature_valid = 1'b0;
    dp.bin18_26_feature_valid = 1'b0;
    dp.bin27_30_feature_valid = 1'b0;
    repeat (3) tick();
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_bram_sel", 32'(dp.bram_sel), 32'd0);
    check("rst_pulses", {29'd0, frame_done, dp.hist_start, dp.histogram_done}, 32'd0);
    check("rst_cell_count", 32'(cell_count), 32'd0);
    check("rst_status", 32'(status), 32'd0);
    arest = 1'b0;
    tick();

    // Normal frame, 3 cells, hist_finish 10 cycles after start.
    hs0 = hs_seen;
    start_frame(16'd3);
    check("t1_hist_start", 32'(dp.hist_start), 32'd1);
    check("t1_busy", 32'(busy), 32'd1);
    check("t1_bram_hist", 32'(dp.bram_sel), 32'd0);
    tick();
    check("t1_hist_start_end", 32'(dp.hist_start), 32'd0);
    repeat (8) tick();
    to_norm("t1");
    strobes(18, 9, 4);
    check("t1_cell1", 32'(cell_count), 32'd1);
    strobes(18, 9, 4);
    strobes(18, 9, 4);
    check("t1_cell3", 32'(cell_count), 32'd3);
    check("t1_fd_early", 32'(frame_done), 32'd0);
    tick();
    check("t1_frame_done", 32'(frame_done), 32'd1);
    check("t1_busy_end", 32'(busy), 32'd0);
    check("t1_bram_end", 32'(dp.bram_sel), 32'd0);
    check("t1_status", 32'(status), 32'd0);
    tick();
    check("t1_fd_one_cycle", 32'(frame_done), 32'd0);
    check("t1_count_hold", 32'(cell_count), 32'd3);
    check("t1_hs_count", 32'(hs_seen - hs0), 32'd1);

    // cfg_cells = 0: immediate cfg_err frame.
    hs0 = hs_seen;
    start_frame(16'd0);
    check("t2_status", 32'(status), 32'd1);
    check("t2_busy", 32'(busy), 32'd1);
    tick();
    check("t2_frame_done", 32'(frame_done), 32'd1);
    check("t2_busy_end", 32'(busy), 32'd0);
    check("t2_no_hist_start", 32'(hs_seen - hs0), 32'd0);

    // Sequence error: only 17 bin0_17 strobes.
    start_frame(16'd1);
    tick();
    to_norm("t3");
    strobes(17, 9, 4);
    check("t3_status", 32'(status), 32'd2);
    check("t3_cell_count", 32'(cell_count), 32'd1);
    tick();
    check("t3_frame_done", 32'(frame_done), 32'd1);

    // Reset in IDLE clears held status and count.
    arest = 1'b1;
    tick();
    arest = 1'b0;
    check("t3_rst_status", 32'(status), 32'd0);
    check("t3_rst_count", 32'(cell_count), 32'd0);
    tick();

    // Abort in NORM after 1 of 2 cells, then a clean restart.
    start_frame(16'd2);
    tick();
    to_norm("t4");
    strobes(18, 9, 4);
    check("t4_cell1", 32'(cell_count), 32'd1);
    fd0 = fd_seen;
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("t4_busy", 32'(busy), 32'd0);
    check("t4_bram_sel", 32'(dp.bram_sel), 32'd0);
    repeat (5) tick();
    check("t4_no_frame_done", 32'(fd_seen - fd0), 32'd0);
    check("t4_count_hold", 32'(cell_count), 32'd1);
    start_frame(16'd1);
    check("t4_restart_count", 32'(cell_count), 32'd0);
    tick();
    to_norm("t4r");
    strobes(18, 9, 4);
    tick();
    check("t4_restart_fd", 32'(frame_done), 32'd1);
    check("t4_restart_status", 32'(status), 32'd0);
    tick();

    // Repeated start in HIST ignored; reset in SETTLE clears everything.
    hs0 = hs_seen;
    start_frame(16'd1);
    start = 1'b1;
    repeat (3) tick();
    start = 1'b0;
    check("t5_one_hist_start", 32'(hs_seen - hs0), 32'd1);
    check("t5_busy", 32'(busy), 32'd1);
    dp.hist_finish = 1'b1;
    tick();
    dp.hist_finish = 1'b0;
    check("t5_settle_bram", 32'(dp.bram_sel), 32'd1);
    fd0 = fd_seen;
    arest = 1'b1;
    tick();
    arest = 1'b0;
    check("t5_rst_busy_bram", {30'd0, busy, dp.bram_sel}, 32'd0);
    check("t5_rst_pulses", {29'd0, frame_done, dp.hist_start, dp.histogram_done}, 32'd0);
    repeat (5) tick();
    check("t5_no_frame_done", 32'(fd_seen - fd0), 32'd0);

    // Feature strobe during HIST flags seq_err, frame still completes.
    start_frame(16'd1);
    dp.bin18_26_feature_valid = 1'b1;
    tick();
    dp.bin18_26_feature_valid = 1'b0;
    tick();
    to_norm("t6");
    strobes(18, 9, 4);
    tick();
    check("t6_frame_done", 32'(frame_done), 32'd1);
    check("t6_status", 32'(status), 32'd2);
    tick();

`ifdef HOG_SEQ_WATCHDOG_EN
    begin
      int n;
      start_frame(16'd1);
      n = 0;
      while (frame_done !== 1'b1 && n < 300) begin
        tick();
        n++;
      end
      check("wd_frame_done", 32'(frame_done), 32'd1);
      check("wd_latency", 32'(n), 32'd101);
      check("wd_status", 32'(status), 32'd4);
      tick();
    end
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
